// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci generator / BCD converter pair.
package fib_pkg;

  localparam int unsigned FIB_W      = 12;
  localparam int unsigned FIB_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } fib_bcd_state_t;

endpackage

// File: rtl/fib_bcd_converter_if.sv
// Handshake bundle between the term source, the converter and the readout stage.
// master: upstream producer / downstream consumer side; slave: the converter.
interface fib_bcd_converter_if
  import fib_pkg::*;
#(
  parameter int unsigned IN_W   = FIB_W,
  parameter int unsigned DIGITS = FIB_DIGITS
);

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     digit_blank;

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, digit_blank
  );

  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, digit_blank
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Pre-shift correction so the following left shift carries into the next digit
  always_comb begin
    o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
  end

endmodule

// File: rtl/fib_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional leading-zero blank mask enabled by defining FIB_BCD_BLANK_EN.
module fib_bcd_converter
  import fib_pkg::*;
#(
  parameter int unsigned IN_W   = FIB_W,
  parameter int unsigned DIGITS = FIB_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  fib_bcd_converter_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + IN_W;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IN_W);

  fib_bcd_state_t    r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [SR_W-1:0]   r_shift;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_out_valid;

  logic [SR_W-1:0]   w_adj;
  logic [SR_W-1:0]   w_next;
  logic              w_finish;

  // One correction cell per BCD digit of the shift register
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_shift[IN_W + 4*g +: 4]),
      .o_digit (w_adj[IN_W + 4*g +: 4])
    );
  end

  assign w_adj[IN_W-1:0] = r_shift[IN_W-1:0];
  assign w_next          = {w_adj[SR_W-2:0], 1'b0};
  assign w_finish        = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(1));

  assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.bcd       = r_bcd;

  // Conversion FSM: accept, shift IN_W times, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_bcd       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_shift <= {{BCD_W{1'b0}}, bus.bin};
            r_cnt   <= CNT_INIT;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_shift <= w_next;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (w_finish) begin
            r_bcd       <= w_next[SR_W-1 -: BCD_W];
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIB_BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_zero;

  // Blank digit i when it and every more-significant digit are zero; units never blank
  always_comb begin
    w_blank = '0;
    w_zero  = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      w_zero     = w_zero && (w_next[IN_W + 4*i +: 4] == 4'd0);
      w_blank[i] = w_zero;
    end
  end

  // Mask captured on the same edge as the final BCD value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blank <= '0;
    end else if (w_finish) begin
      r_blank <= w_blank;
    end
  end

  assign bus.digit_blank = r_blank;
`else
  assign bus.digit_blank = '0;
`endif

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Self-checking bench for fib_bcd_converter; honours FIB_BCD_BLANK_EN when defined.
module tb_fib_bcd_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fib_bcd_converter_if bus ();

  fib_bcd_converter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: decimal digits by plain division
  function automatic logic [15:0] exp_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: digit i blank iff the value has fewer than i+1 decimal digits
  function automatic logic [3:0] exp_blank(input int v);
    logic [3:0] b;
    int p;
    b = '0;
    p = 1;
`ifdef FIB_BCD_BLANK_EN
    for (int i = 1; i < 4; i++) begin
      p = p * 10;
      b[i] = (v < p);
    end
`endif
    return b;
  endfunction

  task automatic start_conv(input int v, output int acc_cyc, output bit ok);
    ok = 1'b0;
    acc_cyc = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      bus.in_valid = 1'b1;
      bus.bin      = 12'(v);
      acc_cyc      = cyc;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.bin      = 12'($urandom);
    end
  endtask

  task automatic wait_done(output int lat, output bit rdy_seen, output bit ok,
                           output logic [15:0] bcd, output logic [3:0] blank);
    lat = 1;
    rdy_seen = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    bcd   = bus.bcd;
    blank = bus.digit_blank;
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.bin = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.bcd !== 16'h0) begin n_fail++; $display("FAIL reset_bcd got %h want 0000", bus.bcd); end
    n_cmp++; if (bus.digit_blank !== 4'h0) begin n_fail++; $display("FAIL reset_blank got %b want 0000", bus.digit_blank); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_high got %b want 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single(input int v);
    int acc, lat;
    bit ok, okd, rdy;
    logic [15:0] b;
    logic [3:0] bl;
    start_conv(v, acc, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_accept v=%0d got timeout want accept", v); end
    wait_done(lat, rdy, okd, b, bl);
    n_cmp++; if (okd !== 1'b1) begin n_fail++; $display("FAIL single_done v=%0d got timeout want out_valid", v); end
    n_cmp++; if (lat !== 13) begin n_fail++; $display("FAIL single_latency v=%0d got %0d want 13", v, lat); end
    n_cmp++; if (b !== exp_bcd(v)) begin n_fail++; $display("FAIL single_bcd v=%0d got %h want %h", v, b, exp_bcd(v)); end
    n_cmp++; if (bl !== exp_blank(v)) begin n_fail++; $display("FAIL single_blank v=%0d got %b want %b", v, bl, exp_blank(v)); end
    n_cmp++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL single_in_ready_busy v=%0d got high want low", v); end
    ack();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_release v=%0d got %b want 0", v, bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    int a0, a1, lat;
    bit ok, okd, rdy;
    logic [15:0] b;
    logic [3:0] bl;
    bus.out_ready = 1'b1;
    start_conv(4095, a0, ok);
    wait_done(lat, rdy, okd, b, bl);
    n_cmp++; if (b !== 16'h4095) begin n_fail++; $display("FAIL b2b_first_bcd got %h want 4095", b); end
    n_cmp++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_first_in_ready got high want low"); end
    start_conv(2584, a1, ok);
    n_cmp++; if ((a1 - a0) !== 14) begin n_fail++; $display("FAIL b2b_spacing got %0d want 14", a1 - a0); end
    wait_done(lat, rdy, okd, b, bl);
    n_cmp++; if (b !== 16'h2584) begin n_fail++; $display("FAIL b2b_second_bcd got %h want 2584", b); end
    n_cmp++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_second_in_ready got high want low"); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_release got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    int acc, lat;
    bit ok, okd, rdy;
    logic [15:0] b;
    logic [3:0] bl;
    bus.out_ready = 1'b0;
    start_conv(987, acc, ok);
    wait_done(lat, rdy, okd, b, bl);
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.bcd !== 16'h0987 || bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cycle=%0d got v=%b bcd=%h rdy=%b want v=1 bcd=0987 rdy=0", k, bus.out_valid, bus.bcd, bus.in_ready);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_ignore_pulse();
    int acc, lat;
    bit ok, okd, rdy;
    logic [15:0] b;
    logic [3:0] bl;
    start_conv(233, acc, ok);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bin = 12'd55;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done(lat, rdy, okd, b, bl);
    n_cmp++; if (b !== 16'h0233) begin n_fail++; $display("FAIL ignore_bcd got %h want 0233", b); end
    n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL ignore_latency got %0d want 9", lat); end
    ack();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL ignore_no_extra got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int acc, lat;
    bit ok, okd, rdy;
    logic [15:0] b;
    logic [3:0] bl;
    start_conv(1597, acc, ok);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.bcd !== 16'h0 || bus.digit_blank !== 4'h0) begin
      n_fail++; $display("FAIL rstmid_clear got v=%b bcd=%h bl=%b want 0/0000/0000", bus.out_valid, bus.bcd, bus.digit_blank);
    end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready got %b want 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready_after got %b want 1", bus.in_ready); end
    repeat (15) @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_residue got %b want 0", bus.out_valid); end
    start_conv(89, acc, ok);
    wait_done(lat, rdy, okd, b, bl);
    n_cmp++; if (b !== 16'h0089) begin n_fail++; $display("FAIL rstmid_next_bcd got %h want 0089", b); end
    n_cmp++; if (bl !== exp_blank(89)) begin n_fail++; $display("FAIL rstmid_next_blank got %b want %b", bl, exp_blank(89)); end
    n_cmp++; if (lat !== 13) begin n_fail++; $display("FAIL rstmid_next_latency got %0d want 13", lat); end
    ack();
  endtask

  task automatic test_random();
    int v, acc, lat, h;
    bit ok, okd, rdy;
    logic [15:0] b;
    logic [3:0] bl;
    for (int n = 0; n < 24; n++) begin
      v = (n == 0) ? 4095 : (n == 1) ? 1000 : (n == 2) ? 9 : int'($urandom_range(0, 4095));
      start_conv(v, acc, ok);
      wait_done(lat, rdy, okd, b, bl);
      n_cmp++; if (okd !== 1'b1 || b !== exp_bcd(v) || bl !== exp_blank(v)) begin
        n_fail++; $display("FAIL rand_result v=%0d got bcd=%h bl=%b want bcd=%h bl=%b", v, b, bl, exp_bcd(v), exp_blank(v));
      end
      h = int'($urandom_range(0, 3));
      for (int k = 0; k < h; k++) begin
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.bcd !== exp_bcd(v)) begin
          n_fail++; $display("FAIL rand_hold v=%0d got v=%b bcd=%h want v=1 bcd=%h", v, bus.out_valid, bus.bcd, exp_bcd(v));
        end
      end
      ack();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.bin       = '0;
    test_reset();
    test_single(0);
    test_single(144);
    test_back_to_back();
    test_backpressure();
    test_ignore_pulse();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_bcd_converter.md
# fib_bcd_converter

Sequential binary-to-BCD converter sitting directly downstream of the Fibonacci generator. Accepts one 12-bit Fibonacci term (0–4095) over a valid/ready handshake and converts it to four packed BCD digits using shift-and-add-3 (double dabble), one bit per clock. It returns the result over a second valid/ready handshake for the display/readout stage.

## Interface
- `IN_W`, 12, binary input width; fixed by the generator's term width.
- `DIGITS`, 4, BCD output digits; must satisfy 10^DIGITS > 2^IN_W − 1.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: `bin` holds a term to convert.
- `in_ready` output 1: converter can accept a term.
- `bin` input IN_W: unsigned binary term.
- `out_valid` output 1: `bcd` holds a completed result.
- `out_ready` input 1: consumer takes the result.
- `bcd` output 4*DIGITS: packed BCD; digit 0 (units) is `[3:0]`.
- `digit_blank` output DIGITS: per-digit leading-zero blank mask (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: `in_ready` = 1. On `in_valid && in_ready`, load shift register {BCD = 0, BIN = `bin`}, set bit counter = IN_W, go to SHIFT.
- SHIFT: each cycle, every BCD digit ≥ 5 gets +3 (4-bit, no carry out of the digit). Then the whole {BCD, BIN} register shifts left 1 and the counter decrements. The cycle in which the counter goes 1→0 moves to DONE.
- DONE: `out_valid` = 1. `bcd` is stable and equals the final BCD field. On `out_valid && out_ready`, go to IDLE.
- `in_ready` = (state == IDLE) && !rst. `in_valid` is ignored outside IDLE and does not need to be held. `bin` is sampled only on the accept edge.
- `bcd` is registered. It updates only on the SHIFT→DONE transition and holds until the next conversion completes.
- Arithmetic: unsigned only. Input 4095 gives 0x4095, with no overflow possible at the default widths.
- Reset, including mid-SHIFT or in DONE: state = IDLE, counter = 0, shift register = 0, `bcd` = 0, `out_valid` = 0, `digit_blank` = 0. The partial conversion is discarded. `in_ready` is 0 while `rst` is high and 1 on the first cycle after deassertion.

## Timing
- Accept on edge E0. IN_W shift edges E1..E12. `out_valid` is high in the cycle after E12, so latency is IN_W+1 edges from accept.
- Minimum period between accepts is IN_W+2 cycles: one DONE cycle with `out_ready` high, then IDLE. No back-to-back overlap.
- Back-pressure: DONE holds indefinitely while `out_ready` = 0. `out_valid` never drops without a handshake or reset.
- `out_ready` high while not in DONE has no effect.

## Configuration
- Macro `FIB_BCD_BLANK_EN`.
- Defined: `digit_blank[i]` = 1 iff digits i..DIGITS−1 are all zero, for i ≥ 1. `digit_blank[0]` is always 0, so value 0 shows a single "0". The mask is registered alongside `bcd` and reset to 0.
- Undefined: `digit_blank` is tied to 0, and no blanking logic is synthesized.

## Structure
- Shared package/header `fib_pkg`:
  - `FIB_W` = 12 and `FIB_DIGITS` = 4 (the generator uses the same constant).
  - FSM state encoding constants `ST_IDLE`, `ST_SHIFT`, `ST_DONE`.
- One combinational sub-module `bcd_digit_adj`: 4-bit in, 4-bit out, adds 3 if input ≥ 5. It is instantiated DIGITS times in a generate loop.

## Test plan
- Reset, then `bin` = 0 accepted → 13 edges later `out_valid` = 1, `bcd` = 0x0000. With `FIB_BCD_BLANK_EN`, `digit_blank` = 4'b1110.
- `bin` = 144 → `bcd` = 0x0144. With `FIB_BCD_BLANK_EN`, `digit_blank` = 4'b1000.
- `bin` = 4095, then `bin` = 2584, each with `out_ready` = 1 → `bcd` = 0x4095 then 0x2584. Accepts are exactly 14 cycles apart, and `in_ready` is low during both conversions.
- `bin` = 987 with `out_ready` held low 5 cycles after `out_valid` → `out_valid` and `bcd` = 0x0987 stay stable for all 5 cycles. The handshake completes on the 6th, and `in_ready` rises next cycle.
- `in_valid` pulsed with `bin` = 55 during SHIFT of a `bin` = 233 conversion → the pulse is ignored and the result is 0x0233.
- `rst` asserted at shift 6 of a `bin` = 1597 conversion → the next cycle shows `out_valid` = 0 and `bcd` = 0. After deassert, a new `bin` = 89 produces 0x0089 with no residue from the aborted conversion.
